// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset sequencing controller:
// states, opcodes, datapath mux/ALU encodings and the bundled control word.
package mc_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem2reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Classifies the instruction register into the one-hot instruction classes
// that steer the sequencing FSM out of DECODE.
module mc_opcode_decode
    import mc_control_pkg::*;
(
    input  logic [31:0] inst,
    output logic        is_rtype,
    output logic        is_nop,
    output logic        is_imm,
    output logic        is_lw,
    output logic        is_sw,
    output logic        is_branch,
    output logic        is_bne,
    output logic        is_jump,
    output logic        is_illegal
);

    logic [5:0] opcode;
    assign opcode = inst[31:26];

    always_comb begin
        is_rtype   = 1'b0;
        is_nop     = (inst == 32'd0);
        is_imm     = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_branch  = 1'b0;
        is_bne     = 1'b0;
        is_jump    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_RTYPE:         is_rtype = !is_nop;
            OP_ADDI, OP_ANDI: is_imm = 1'b1;
            OP_LW:            is_lw = 1'b1;
            OP_SW:            is_sw = 1'b1;
            OP_BEQ:           is_branch = 1'b1;
            OP_BNE: begin
                is_branch = 1'b1;
                is_bne    = 1'b1;
            end
            OP_J:             is_jump = 1'b1;
            default:          is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle sequencing FSM driving the shared-memory MIPS-subset datapath.
// state | meaning: FETCH ifetch+PC+4 | DECODE branch target | MEM_ADDR ea | MEM_RD load | MEM_WB load wb
//   MEM_WR store | R_EXEC/R_WB R-type | BRANCH beq/bne | JUMP j | I_EXEC/I_WB addi/andi
module mc_control
    import mc_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem2reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        done,
    output logic        illegal,
    output logic [3:0]  state
);

    state_e state_q, state_d;
    ctrl_t  ctrl_c, ctrl_o;
    logic   is_rtype, is_nop, is_imm, is_lw, is_sw, is_branch, is_bne, is_jump, is_illegal;

    mc_opcode_decode u_decode (
        .inst       (inst),
        .is_rtype   (is_rtype),
        .is_nop     (is_nop),
        .is_imm     (is_imm),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .is_branch  (is_branch),
        .is_bne     (is_bne),
        .is_jump    (is_jump),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ctrl_c       = '0;
        ctrl_c.state = state_q;
        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.pc_src    = PC_ALU;
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_en     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = SRCB_IMM_SH2;
                ctrl_c.alu_op    = ALU_ADD;
                state_d          = S_FETCH;
                if (is_lw || is_sw)          state_d = S_MEM_ADDR;
                else if (is_rtype)           state_d = S_R_EXEC;
                else if (is_imm)             state_d = S_I_EXEC;
                else if (is_branch)          state_d = S_BRANCH;
                else if (is_jump)            state_d = S_JUMP;
                else if (is_nop || is_illegal) begin
                    ctrl_c.done    = 1'b1;
                    ctrl_c.illegal = is_illegal;
                end
            end
            S_MEM_ADDR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALU_ADD;
                state_d          = is_lw ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.iord     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.mem2reg   = 1'b1;
                ctrl_c.done      = 1'b1;
                state_d          = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.iord      = 1'b1;
                ctrl_c.done      = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REG;
                ctrl_c.alu_op    = ALU_FUNCT;
                state_d          = S_R_WB;
            end
            S_R_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.done      = 1'b1;
                state_d          = S_FETCH;
            end
            S_I_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALU_IMM;
                state_d          = S_I_WB;
            end
            S_I_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.done      = 1'b1;
                state_d          = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REG;
                ctrl_c.alu_op    = ALU_SUB;
                ctrl_c.pc_src    = PC_ALUOUT;
                ctrl_c.pc_en     = zero ^ is_bne;
                ctrl_c.done      = 1'b1;
                state_d          = S_FETCH;
            end
            S_JUMP: begin
                ctrl_c.pc_src = PC_JUMP;
                ctrl_c.pc_en  = 1'b1;
                ctrl_c.done   = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every output, including the FETCH strobes the idle state would drive.
    assign ctrl_o    = rst_n ? ctrl_c : '0;
    assign state     = ctrl_o.state;
    assign pc_en     = ctrl_o.pc_en;
    assign pc_src    = ctrl_o.pc_src;
    assign iord      = ctrl_o.iord;
    assign mem_read  = ctrl_o.mem_read;
    assign mem_write = ctrl_o.mem_write;
    assign ir_write  = ctrl_o.ir_write;
    assign reg_dst   = ctrl_o.reg_dst;
    assign mem2reg   = ctrl_o.mem2reg;
    assign reg_write = ctrl_o.reg_write;
    assign alu_src_a = ctrl_o.alu_src_a;
    assign alu_src_b = ctrl_o.alu_src_b;
    assign alu_op    = ctrl_o.alu_op;
    assign done      = ctrl_o.done;
    assign illegal   = ctrl_o.illegal;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-instruction expected cycle sequences are
// built from the instruction class and wait counts, then compared every cycle.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem2reg, reg_write;
    logic        alu_src_a, done, illegal;
    logic [1:0]  pc_src, alu_src_b, alu_op;
    logic [3:0]  state;

    mc_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst      (inst),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_en     (pc_en),
        .pc_src    (pc_src),
        .iord      (iord),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .ir_write  (ir_write),
        .reg_dst   (reg_dst),
        .mem2reg   (mem2reg),
        .reg_write (reg_write),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .done      (done),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord, mem_read, mem_write, ir_write, reg_dst, mem2reg, reg_write, src_a;
        logic [1:0] src_b, alu_op;
        logic       done, illegal;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  ready;
    } step_t;

    outs_t act, exp_cur;
    step_t q[$];
    int    vectors = 0, miscompares = 0, done_cnt = 0, illegal_cnt = 0, trace_idx = 0;
    bit    chk_en = 1'b0, pin_trace = 1'b0, final_chk = 1'b0, rnd_ready = 1'b0;
    logic [3:0] lw_trace [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

    assign act = {state, pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                  mem2reg, reg_write, alu_src_a, alu_src_b, alu_op, done, illegal};

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (act !== exp_cur) begin
                miscompares++;
                $display("FAIL outputs t=%0t got %h expected %h (state got %0d expected %0d)",
                         $time, act, exp_cur, act.st, exp_cur.st);
            end
            if (done === 1'b1) done_cnt++;
            if (illegal === 1'b1) illegal_cnt++;
            if (pin_trace && trace_idx < 5) begin
                vectors++;
                if (state !== lw_trace[trace_idx]) begin
                    miscompares++;
                    $display("FAIL lw_trace[%0d] got %0d expected %0d", trace_idx, state, lw_trace[trace_idx]);
                end
                trace_idx++;
            end
        end
        if (final_chk) begin
            vectors += 2;
            if (done_cnt != 15) begin
                miscompares++;
                $display("FAIL done_count got %0d expected 15", done_cnt);
            end
            if (illegal_cnt != 1) begin
                miscompares++;
                $display("FAIL illegal_count got %0d expected 1", illegal_cnt);
            end
        end
    end

    task automatic push(input outs_t e, input logic r);
        step_t s;
        s.o   = e;
        s.ready = r;
        q.push_back(s);
    endtask

    function automatic logic rdy();
        return rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // Expected sequence: fetch (fw waits), decode, class-specific steps (mw memory waits).
    task automatic run_instr(input logic [31:0] ins, input logic z, input int fw, input int mw, input int limit);
        outs_t e;
        logic [5:0] op;
        op = ins[31:26];
        q.delete();
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_read = 1'b1; e.src_b = 2'b01;
            push(e, 1'b0);
        end
        e = '0; e.mem_read = 1'b1; e.src_b = 2'b01; e.ir_write = 1'b1; e.pc_en = 1'b1;
        push(e, 1'b1);
        e = '0; e.st = 4'd1; e.src_b = 2'b11;
        if (ins == 32'd0) begin
            e.done = 1'b1;
            push(e, rdy());
        end else if (op == 6'h23 || op == 6'h2b) begin
            push(e, rdy());
            e = '0; e.st = 4'd2; e.src_a = 1'b1; e.src_b = 2'b10;
            push(e, rdy());
            e = '0; e.st = (op == 6'h23) ? 4'd3 : 4'd5; e.iord = 1'b1;
            e.mem_read = (op == 6'h23); e.mem_write = (op == 6'h2b);
            for (int i = 0; i < mw; i++) push(e, 1'b0);
            e.done = (op == 6'h2b);
            push(e, 1'b1);
            if (op == 6'h23) begin
                e = '0; e.st = 4'd4; e.reg_write = 1'b1; e.mem2reg = 1'b1; e.done = 1'b1;
                push(e, rdy());
            end
        end else if (op == 6'h00) begin
            push(e, rdy());
            e = '0; e.st = 4'd6; e.src_a = 1'b1; e.alu_op = 2'b10;
            push(e, rdy());
            e = '0; e.st = 4'd7; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.done = 1'b1;
            push(e, rdy());
        end else if (op == 6'h08 || op == 6'h0c) begin
            push(e, rdy());
            e = '0; e.st = 4'd10; e.src_a = 1'b1; e.src_b = 2'b10; e.alu_op = 2'b11;
            push(e, rdy());
            e = '0; e.st = 4'd11; e.reg_write = 1'b1; e.done = 1'b1;
            push(e, rdy());
        end else if (op == 6'h04 || op == 6'h05) begin
            push(e, rdy());
            e = '0; e.st = 4'd8; e.src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.done = 1'b1;
            e.pc_en = z ^ (op == 6'h05);
            push(e, rdy());
        end else if (op == 6'h02) begin
            push(e, rdy());
            e = '0; e.st = 4'd9; e.pc_src = 2'b10; e.pc_en = 1'b1; e.done = 1'b1;
            push(e, rdy());
        end else begin
            e.done = 1'b1; e.illegal = 1'b1;
            push(e, rdy());
        end
        inst = ins;
        zero = z;
        for (int k = 0; k < q.size() && (limit < 0 || k < limit); k++) begin
            mem_ready = q[k].ready;
            exp_cur   = q[k].o;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        exp_cur   = '0;
        mem_ready = 1'b1;
        chk_en    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        pin_trace = 1'b1;
        run_instr(32'h8C220004, 1'b0, 0, 0, -1);     // lw, ready high
        pin_trace = 1'b0;
        run_instr(32'h00430820, 1'b0, 3, 0, -1);     // add, 3 fetch waits
        run_instr(32'h10220003, 1'b1, 0, 0, -1);     // beq taken
        run_instr(32'h14220003, 1'b1, 0, 0, -1);     // bne not taken
        run_instr(32'h10220003, 1'b0, 0, 0, -1);     // beq not taken
        run_instr(32'h14220003, 1'b0, 0, 0, -1);     // bne taken
        run_instr(32'h00000000, 1'b0, 0, 0, -1);     // nop
        run_instr(32'hFC000000, 1'b0, 0, 0, -1);     // illegal opcode
        run_instr(32'hAC220008, 1'b0, 0, 2, -1);     // sw, 2 memory waits
        rnd_ready = 1'b1;
        run_instr(32'h20220005, 1'b1, 0, 0, -1);     // addi
        run_instr(32'h3022000F, 1'b0, 0, 0, -1);     // andi
        run_instr(32'h08000010, 1'b0, 0, 0, -1);     // j
        run_instr(32'h8C220004, 1'b0, 1, 2, -1);     // lw with waits
        rnd_ready = 1'b0;

        // Abandon a lw while it waits in MEM_RD.
        run_instr(32'h8C220004, 1'b0, 0, 3, 4);
        exp_cur   = '0;
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(32'h00000000, 1'b0, 0, 0, -1);
        run_instr(32'h00430820, 1'b0, 0, 0, -1);

        chk_en    = 1'b0;
        final_chk = 1'b1;
        @(negedge clk);
        #1;
        final_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
